// File: rtl/plic_irq_gateway.sv
// Interrupt gateway in front of the PLIC: synchronise, qualify level/edge, latch pending, gate claim/complete.
// Optional macro PLIC_GW_EDGE_COUNT_EN: each edge source counts extra edges in a CNT_W-bit saturating counter.
module plic_irq_gateway #(
  parameter int                 NUM_SRC     = 32,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
  parameter int                 CNT_W       = 4,
  localparam int                ID_W        = $clog2(NUM_SRC)
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [NUM_SRC-1:0] enable_i,
  output logic [NUM_SRC-1:0] irq_pending_o,
  output logic [NUM_SRC-1:0] inflight_o,
  input  logic               claim_valid_i,
  input  logic [ID_W-1:0]    claim_id_i,
  input  logic               complete_valid_i,
  input  logic [ID_W-1:0]    complete_id_i
);
  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, INFLIGHT = 2'd2} state_e;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]                  sync;
  logic                                unused_inputs;

`ifndef PLIC_GW_EDGE_COUNT_EN
  localparam int unused_cnt_w = CNT_W;
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {irq_src_i[NUM_SRC-1:1], 1'b0};
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end
  assign sync = sync_q[SYNC_STAGES-1];

  // Line 0 is reserved and never requests
  assign irq_pending_o[0] = 1'b0;
  assign inflight_o[0]    = 1'b0;
  assign unused_inputs    = ^{irq_src_i[0], enable_i[0], sync[0]};

  for (genvar gi = 1; gi < NUM_SRC; gi++) begin : g_src
    localparam bit IS_EDGE = EDGE_MASK[gi];

    state_e state_q, state_d;
    logic   rise, trig, claim_hit, complete_hit, extra_edge, repend;

    if (IS_EDGE) begin : g_edge
      logic edge_q;
      always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
          edge_q <= 1'b0;
        end else begin
          edge_q <= sync[gi];
        end
      end
      assign rise = sync[gi] & ~edge_q;
    end else begin : g_level
      assign rise = 1'b0;
    end

    assign trig         = IS_EDGE ? rise : sync[gi];
    assign claim_hit    = claim_valid_i && (claim_id_i == ID_W'(gi)) && irq_pending_o[gi];
    assign complete_hit = complete_valid_i && (complete_id_i == ID_W'(gi)) && (state_q == INFLIGHT);
    assign repend       = (!IS_EDGE && sync[gi] && enable_i[gi]) || extra_edge;

`ifdef PLIC_GW_EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
    assign extra_edge = (cnt_q != '0);

    // Decrement for the re-pend first so a same-cycle edge is still counted
    always_comb begin
      cnt_dec = (complete_hit && extra_edge) ? cnt_q - CNT_W'(1) : cnt_q;
      cnt_d   = cnt_dec;
      if (rise && enable_i[gi] && (state_q != IDLE) && (cnt_dec != '1)) begin
        cnt_d = cnt_dec + CNT_W'(1);
      end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
`else
    // Any number of edges seen while INFLIGHT merge into a single re-pend
    logic edge_seen_q, edge_seen_d;
    assign extra_edge  = edge_seen_q;
    assign edge_seen_d = (edge_seen_q && !complete_hit) ||
                         (rise && enable_i[gi] && (state_q == INFLIGHT));

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        edge_seen_q <= 1'b0;
      end else begin
        edge_seen_q <= edge_seen_d;
      end
    end
`endif

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE: begin
          if (trig && enable_i[gi]) state_d = PENDING;
        end
        PENDING: begin
          if (claim_hit) state_d = INFLIGHT;
          else if (!IS_EDGE && !sync[gi]) state_d = IDLE;
        end
        INFLIGHT: begin
          if (complete_hit) state_d = repend ? PENDING : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Masking is combinational so it takes effect in the same cycle
    assign irq_pending_o[gi] = (state_q == PENDING) && enable_i[gi];
    assign inflight_o[gi]    = (state_q == INFLIGHT);
  end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Scoreboard bench for plic_irq_gateway: directed test-plan sequences followed by random traffic.
module tb_plic_irq_gateway;
  localparam int N   = 6;
  localparam int S   = 2;
  localparam int CW  = 2;
  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] EDGE = 6'b001100;
  localparam int ST_IDLE = 0;
  localparam int ST_PEND = 1;
  localparam int ST_INFL = 2;
`ifdef PLIC_GW_EDGE_COUNT_EN
  localparam int CAP = (1 << CW) - 1;
  localparam bit COUNT_IN_PEND = 1'b1;
`else
  localparam int CAP = 1;
  localparam bit COUNT_IN_PEND = 1'b0;
`endif

  logic           clock_i = 1'b0;
  logic           reset_ni = 1'b0;
  logic [N-1:0]   irq_src_i = '0;
  logic [N-1:0]   enable_i = '0;
  logic [N-1:0]   irq_pending_o;
  logic [N-1:0]   inflight_o;
  logic           claim_valid_i = 1'b0;
  logic [IDW-1:0] claim_id_i = '0;
  logic           complete_valid_i = 1'b0;
  logic [IDW-1:0] complete_id_i = '0;

  plic_irq_gateway #(
    .NUM_SRC(N), .SYNC_STAGES(S), .EDGE_MASK(EDGE), .CNT_W(CW)
  ) dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .irq_src_i(irq_src_i), .enable_i(enable_i),
    .irq_pending_o(irq_pending_o), .inflight_o(inflight_o),
    .claim_valid_i(claim_valid_i), .claim_id_i(claim_id_i),
    .complete_valid_i(complete_valid_i), .complete_id_i(complete_id_i)
  );

  always #5 clock_i = ~clock_i;

  // Stimulus intent for the next cycle
  logic [N-1:0] src_v = '0;
  logic [N-1:0] en_v = '1;
  bit rst_v = 1'b0, clm_v = 1'b0, cmp_v = 1'b0;
  int cid_v = 0, cpid_v = 0, cyc = 0;

  // Reference model: per-source state, extra-edge count, and history of sampled inputs
  int st[N];
  int cnt[N];
  logic [N-1:0] hq[$];

  typedef struct { logic [N-1:0] pend; logic [N-1:0] infl; int cyc; } exp_t;
  exp_t expq[$];

  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, expv);
    end
  endfunction

  function automatic logic [N-1:0] exp_pend();
    logic [N-1:0] r = '0;
    for (int n = 1; n < N; n++) r[n] = (st[n] == ST_PEND) && en_v[n];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_infl();
    logic [N-1:0] r = '0;
    for (int n = 1; n < N; n++) r[n] = (st[n] == ST_INFL);
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      st[n] = ST_IDLE;
      cnt[n] = 0;
    end
    hq.delete();
    repeat (S + 1) hq.push_back('0);
  endtask

  // One clock edge: the source is seen S edges after being sampled
  task automatic model_edge();
    logic [N-1:0] syn, prv;
    syn = hq[S-1];
    prv = hq[S];
    for (int n = 1; n < N; n++) begin
      bit is_edge, rise, hit_c, hit_p;
      int nst, c;
      is_edge = EDGE[n];
      rise    = is_edge && syn[n] && !prv[n];
      nst     = st[n];
      c       = cnt[n];
      hit_c   = clm_v && (cid_v == n) && (st[n] == ST_PEND) && en_v[n];
      hit_p   = cmp_v && (cpid_v == n) && (st[n] == ST_INFL);
      if (st[n] == ST_IDLE) begin
        if (en_v[n] && (is_edge ? rise : syn[n])) nst = ST_PEND;
      end else if (st[n] == ST_PEND) begin
        if (hit_c) nst = ST_INFL;
        else if (!is_edge && !syn[n]) nst = ST_IDLE;
      end else if (hit_p) begin
        nst = ((!is_edge && syn[n] && en_v[n]) || c > 0) ? ST_PEND : ST_IDLE;
        if (c > 0) c--;
      end
      if (rise && en_v[n] && (st[n] == ST_INFL || (COUNT_IN_PEND && st[n] == ST_PEND)))
        c = (c + 1 > CAP) ? CAP : c + 1;
      st[n]  = nst;
      cnt[n] = c;
    end
    hq.push_front(src_v);
    void'(hq.pop_back());
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clock_i);
    reset_ni         = rst_v;
    irq_src_i        = src_v;
    enable_i         = en_v;
    claim_valid_i    = clm_v;
    claim_id_i       = IDW'(cid_v);
    complete_valid_i = cmp_v;
    complete_id_i    = IDW'(cpid_v);
    if (!rst_v) model_reset();
    e.pend = exp_pend();
    e.infl = exp_infl();
    e.cyc  = cyc;
    expq.push_back(e);
    if (clm_v || cmp_v)
      $display("cycle %0d: claim=%0b id=%0d complete=%0b id=%0d src=%b en=%b", cyc, clm_v, cid_v,
               cmp_v, cpid_v, src_v, en_v);
    @(posedge clock_i);
    if (rst_v) model_edge();
    cyc++;
    clm_v = 1'b0;
    cmp_v = 1'b0;
  endtask

  task automatic run(int k);
    repeat (k) cycle();
  endtask

  task automatic claim(int id);
    clm_v = 1'b1;
    cid_v = id;
    cycle();
  endtask

  task automatic complete(int id);
    cmp_v  = 1'b1;
    cpid_v = id;
    cycle();
  endtask

  task automatic pulse(int n);
    src_v[n] = 1'b1;
    cycle();
    src_v[n] = 1'b0;
    run(2);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_i);
      #1;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        chk($sformatf("pending@cycle%0d", e.cyc), irq_pending_o, e.pend);
        chk($sformatf("inflight@cycle%0d", e.cyc), inflight_o, e.infl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_v = 1'b0;
    run(3);
    rst_v = 1'b1;
    run(2);

    // Level source 4: latency, claim, complete with source still high
    src_v[4] = 1'b1;
    run(5);
    claim(4);
    run(3);
    complete(4);
    run(2);
    claim(4);
    src_v[4] = 1'b0;
    run(2);
    complete(4);
    run(4);

    // Edge source 2: five extra pulses while INFLIGHT
    pulse(2);
    run(2);
    claim(2);
    repeat (5) pulse(2);
    run(2);
    complete(2);
    run(1);
    repeat (4) begin
      claim(2);
      run(1);
      complete(2);
      run(1);
    end

    // Masking of a pending level source
    src_v[1] = 1'b1;
    run(4);
    en_v[1] = 1'b0;
    run(1);
    claim(1);
    en_v[1] = 1'b1;
    run(1);
    claim(1);
    src_v[1] = 1'b0;
    run(3);
    complete(1);
    run(4);

    // Illegal IDs and complete of an IDLE source
    claim(0);
    claim(N);
    claim(7);
    complete(3);
    complete(0);
    run(1);

    // Simultaneous claim 3 / complete 5
    src_v[5] = 1'b1;
    run(4);
    claim(5);
    pulse(3);
    run(1);
    clm_v = 1'b1; cid_v = 3; cmp_v = 1'b1; cpid_v = 5;
    cycle();
    run(2);
    claim(5);
    complete(3);

    // Asynchronous reset with sources 2 and 5 INFLIGHT
    pulse(2);
    run(1);
    claim(2);
    run(1);
    src_v = '0;
    #6;
    chk("pre_reset_inflight", inflight_o, exp_infl());
    chk("pre_reset_pending", irq_pending_o, exp_pend());
    rst_v = 1'b0;
    reset_ni = 1'b0;
    #1;
    model_reset();
    chk("async_reset_pending", irq_pending_o, exp_pend());
    chk("async_reset_inflight", inflight_o, exp_infl());
    run(2);
    rst_v = 1'b1;
    run(8);

    // Random traffic
    for (int c = 0; c < 700; c++) begin
      int r;
      int cands[$];
      for (int n = 1; n < N; n++) begin
        if ($urandom_range(0, 7) == 0) src_v[n] = ~src_v[n];
        if ($urandom_range(0, 15) == 0) en_v[n] = ~en_v[n];
      end
      r = $urandom_range(0, 3);
      if (r == 0) begin
        clm_v = 1'b1;
        cid_v = $urandom_range(0, 7);
      end else if (r == 1) begin
        for (int n = 1; n < N; n++) if (st[n] == ST_PEND && en_v[n]) cands.push_back(n);
        if (cands.size() > 0) begin
          clm_v = 1'b1;
          cid_v = cands[$urandom_range(0, cands.size() - 1)];
        end
      end
      cands.delete();
      r = $urandom_range(0, 3);
      if (r == 0) begin
        cmp_v  = 1'b1;
        cpid_v = $urandom_range(0, 7);
      end else if (r == 1) begin
        for (int n = 1; n < N; n++) if (st[n] == ST_INFL) cands.push_back(n);
        if (cands.size() > 0) begin
          cmp_v  = 1'b1;
          cpid_v = cands[$urandom_range(0, cands.size() - 1)];
        end
      end
      cycle();
    end

    run(2);
    #2;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
